// File: rtl/countdown_timer_bcd_pkg.sv
// Shared types and BCD helpers for the countdown timer.
package timer_pkg;

    localparam int unsigned BCD_W      = 4;
    localparam int unsigned MAX_DIGITS = 6;
    localparam int unsigned MAX_W      = BCD_W * MAX_DIGITS;

    typedef enum logic [1:0] {
        IDLE,
        RUNNING,
        PAUSED,
        DONE
    } timer_state_t;

    // Clamp every nibble above 9 down to 9.
    function automatic logic [MAX_W-1:0] bcd_clamp(input logic [MAX_W-1:0] value);
        logic [MAX_W-1:0] result;
        result = value;
        for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
            if (value[i*BCD_W +: BCD_W] > 4'd9) begin
                result[i*BCD_W +: BCD_W] = 4'd9;
            end
        end
        return result;
    endfunction

    // Decrement the lowest 'digits' BCD digits by one, borrowing upward.
    // Callers only use this on a non-zero value, so it never wraps.
    function automatic logic [MAX_W-1:0] bcd_decrement(input logic [MAX_W-1:0] value,
                                                       input int unsigned     digits);
        logic [MAX_W-1:0] result;
        logic             borrow;
        result = value;
        borrow = 1'b1;
        for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
            if (i < digits && borrow) begin
                if (result[i*BCD_W +: BCD_W] == 4'd0) begin
                    result[i*BCD_W +: BCD_W] = 4'd9;
                end else begin
                    result[i*BCD_W +: BCD_W] = result[i*BCD_W +: BCD_W] - 4'd1;
                    borrow = 1'b0;
                end
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/countdown_timer_bcd_tick_divider.sv
// Rate divider: counts enabled cycles and strobes Tick on the last one of each period.
module tick_divider #(
    parameter int unsigned CLK_HZ  = 50000000,
    parameter int unsigned TICK_HZ = 1
) (
    input  logic Clock,
    input  logic Reset,
    input  logic Enable,
    input  logic Clear,
    output logic Tick
);

    localparam int unsigned DIV   = CLK_HZ / TICK_HZ;
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] div_count;

    // Combinational strobe so the parent can act on the same edge the counter wraps.
    assign Tick = Enable && (div_count == DIV_LAST);

    // Divider counter; held when not enabled so a paused period keeps its progress.
    always_ff @(posedge Clock) begin
        if (!Reset || Clear) begin
            div_count <= '0;
        end else if (Enable) begin
            div_count <= Tick ? '0 : div_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/countdown_timer_bcd.sv
// BCD countdown timer with load, start/pause, one-shot or auto-reload, and done/expiry flags.
module countdown_timer_bcd
    import timer_pkg::*;
#(
    parameter int unsigned               CLK_HZ      = 50000000,
    parameter int unsigned               TICK_HZ     = 1,
    parameter int unsigned               DIGITS      = 3,
    parameter logic [4*DIGITS-1:0]       RESET_VALUE = 12'h120
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Load,
    input  logic [4*DIGITS-1:0]   LoadValue,
    input  logic                  Start,
    input  logic                  Pause,
    input  logic                  AutoReload,
    output logic [4*DIGITS-1:0]   Count,
    output logic                  Running,
    output logic                  Done,
    output logic                  Expired,
    output logic                  Tick
);

    localparam int unsigned W = BCD_W * DIGITS;

    timer_state_t state;
    logic [W-1:0] reload_value;
    logic [W-1:0] load_clamped;
    logic [W-1:0] count_dec;
    logic         div_enable;
    logic         div_tick;

    assign load_clamped = W'(bcd_clamp(MAX_W'(LoadValue)));
    assign count_dec    = W'(bcd_decrement(MAX_W'(Count), DIGITS));

    // Load and Pause both stop the divider on the edge they arrive, so a
    // coinciding tick is never produced rather than produced and discarded.
    assign div_enable = (state == RUNNING) && !Load && !Pause;

    tick_divider #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ)
    ) u_tick_divider (
        .Clock  (Clock),
        .Reset  (Reset),
        .Enable (div_enable),
        .Clear  (Load),
        .Tick   (div_tick)
    );

    // Control FSM, BCD counter and reload register with registered status outputs.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            Count        <= RESET_VALUE;
            reload_value <= RESET_VALUE;
            state        <= IDLE;
            Running      <= 1'b0;
            Done         <= 1'b0;
            Expired      <= 1'b0;
            Tick         <= 1'b0;
        end else begin
            Expired <= 1'b0;
            Tick    <= div_tick;
            if (Load) begin
                Count        <= load_clamped;
                reload_value <= load_clamped;
                state        <= IDLE;
                Running      <= 1'b0;
                Done         <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (Start && !Pause) begin
                            if (Count == '0) begin
                                state <= DONE;
                                Done  <= 1'b1;
                            end else begin
                                state   <= RUNNING;
                                Running <= 1'b1;
                            end
                        end
                    end
                    RUNNING: begin
                        if (Pause) begin
                            state   <= PAUSED;
                            Running <= 1'b0;
                        end else if (div_tick) begin
                            if (Count == '0) begin
                                // Zero held for one period in auto-reload; reload now.
                                if (AutoReload) begin
                                    Count <= reload_value;
                                end else begin
                                    state   <= DONE;
                                    Running <= 1'b0;
                                    Done    <= 1'b1;
                                end
                            end else begin
                                Count <= count_dec;
                                if (count_dec == '0) begin
                                    Expired <= 1'b1;
                                    if (!AutoReload) begin
                                        state   <= DONE;
                                        Running <= 1'b0;
                                        Done    <= 1'b1;
                                    end
                                end
                            end
                        end
                    end
                    PAUSED: begin
                        if (Start && !Pause) begin
                            state   <= RUNNING;
                            Running <= 1'b1;
                        end
                    end
                    DONE: begin
                    end
                    default: begin
                        state   <= IDLE;
                        Running <= 1'b0;
                        Done    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_countdown_timer_bcd.sv
// Randomized and directed bench for countdown_timer_bcd against a decimal behavioural model.
module tb_countdown_timer_bcd;

    localparam int          DIV = 10;
    localparam logic [11:0] RV  = 12'h120;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic        Clock;
    logic        Reset;
    logic        Load;
    logic [11:0] LoadValue;
    logic        Start;
    logic        Pause;
    logic        AutoReload;
    logic [11:0] Count;
    logic        Running;
    logic        Done;
    logic        Expired;
    logic        Tick;

    countdown_timer_bcd #(
        .CLK_HZ      (10),
        .TICK_HZ     (1),
        .DIGITS      (3),
        .RESET_VALUE (RV)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Load       (Load),
        .LoadValue  (LoadValue),
        .Start      (Start),
        .Pause      (Pause),
        .AutoReload (AutoReload),
        .Count      (Count),
        .Running    (Running),
        .Done       (Done),
        .Expired    (Expired),
        .Tick       (Tick)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Decimal value of a BCD word, each digit clamped to 9.
    function automatic int bcd_to_int(input logic [11:0] v);
        int d;
        int r;
        int scale;
        r = 0;
        scale = 1;
        for (int i = 0; i < 3; i++) begin
            d = int'(v[i*4 +: 4]);
            if (d > 9) d = 9;
            r = r + d * scale;
            scale = scale * 10;
        end
        return r;
    endfunction

    function automatic logic [11:0] int_to_bcd(input int n);
        return 12'(((n / 100) % 10) * 256 + ((n / 10) % 10) * 16 + (n % 10));
    endfunction

    // Behavioural model: decimal count, cycle position within the tick period, mode.
    int m_count  = 0;
    int m_reload = 0;
    int m_phase  = 0;
    int m_mode   = M_IDLE;
    bit m_tick   = 0;
    bit m_exp    = 0;

    always @(posedge Clock) begin
        m_tick = 0;
        m_exp  = 0;
        if (!Reset) begin
            m_count  = bcd_to_int(RV);
            m_reload = m_count;
            m_phase  = 0;
            m_mode   = M_IDLE;
        end else if (Load) begin
            m_count  = bcd_to_int(LoadValue);
            m_reload = m_count;
            m_phase  = 0;
            m_mode   = M_IDLE;
        end else if (m_mode == M_IDLE) begin
            if (Start && !Pause) m_mode = (m_count != 0) ? M_RUN : M_DONE;
        end else if (m_mode == M_RUN) begin
            if (Pause) begin
                m_mode = M_PAUSE;
            end else begin
                m_phase++;
                if (m_phase == DIV) begin
                    m_phase = 0;
                    m_tick  = 1;
                    if (m_count == 0) begin
                        if (AutoReload) m_count = m_reload;
                        else m_mode = M_DONE;
                    end else begin
                        m_count--;
                        if (m_count == 0) begin
                            m_exp = 1;
                            if (!AutoReload) m_mode = M_DONE;
                        end
                    end
                end
            end
        end else if (m_mode == M_PAUSE) begin
            if (Start && !Pause) m_mode = M_RUN;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(posedge Clock) begin
        #1;
        if (chk_en) begin
            check("count",   int'(Count),   int'(int_to_bcd(m_count)));
            check("running", int'(Running), int'(m_mode == M_RUN));
            check("done",    int'(Done),    int'(m_mode == M_DONE));
            check("expired", int'(Expired), int'(m_exp));
            check("tick",    int'(Tick),    int'(m_tick));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge Clock);
        #2;
    endtask

    int          exp_cnt;
    int          done_cnt;
    int          tick_cnt;
    int          k;
    logic [11:0] exp_val;
    logic [11:0] seq[$];
    logic [11:0] want_seq[5];

    initial begin
        Reset = 0; Load = 0; LoadValue = '0; Start = 0; Pause = 0; AutoReload = 0;
        cyc(2);
        chk_en = 1;
        check("reset_count", int'(Count), int'(12'h120));
        check("reset_flags", int'({Running, Done, Expired, Tick}), 0);

        // 1: start from reset value, first tick after DIV cycles, two-digit borrow
        Reset = 1; Start = 1;
        cyc(1);
        Start = 0;
        check("t1_running", int'(Running), 1);
        check("t1_count0", int'(Count), int'(12'h120));
        cyc(9);
        check("t1_no_early_tick", int'(Tick), 0);
        cyc(1);
        check("t1_first_tick", int'(Tick), 1);
        check("t1_count119", int'(Count), int'(12'h119));
        cyc(200);
        check("t1_count099", int'(Count), int'(12'h099));

        // 2: one-shot expiry
        Load = 1; LoadValue = 12'h003;
        cyc(1);
        Load = 0; Start = 1;
        cyc(1);
        Start = 0;
        exp_cnt = 0; exp_val = 12'hFFF;
        for (int i = 0; i < 40; i++) begin
            cyc(1);
            if (Expired) begin exp_cnt++; exp_val = Count; end
        end
        check("t2_expired_once", exp_cnt, 1);
        check("t2_count_at_expiry", int'(exp_val), 0);
        check("t2_done", int'(Done), 1);
        Start = 1;
        cyc(5);
        Start = 0;
        check("t2_start_ignored_count", int'(Count), 0);
        check("t2_start_ignored_run", int'(Running), 0);

        // 3: pause mid-period keeps the partial period
        Load = 1; LoadValue = 12'h050;
        cyc(1);
        Load = 0; Start = 1;
        cyc(1);
        Start = 0;
        cyc(4);
        Pause = 1;
        tick_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            cyc(1);
            if (Tick) tick_cnt++;
        end
        check("t3_no_tick_paused", tick_cnt, 0);
        check("t3_count_held", int'(Count), int'(12'h050));
        Pause = 0; Start = 1;
        cyc(1);
        Start = 0;
        k = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            k++;
            if (Tick) break;
        end
        check("t3_tick_after_resume", k, 6);

        // 4: auto-reload sequence
        AutoReload = 1; Load = 1; LoadValue = 12'h002;
        cyc(1);
        Load = 0; Start = 1;
        cyc(1);
        Start = 0;
        seq.delete();
        exp_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 80; i++) begin
            cyc(1);
            if (Tick) seq.push_back(Count);
            if (Expired) exp_cnt++;
            if (Done) done_cnt++;
            if (seq.size() == 5) break;
        end
        want_seq[0] = 12'h001; want_seq[1] = 12'h000; want_seq[2] = 12'h002;
        want_seq[3] = 12'h001; want_seq[4] = 12'h000;
        check("t4_tick_count", seq.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < seq.size()) check("t4_seq", int'(seq[i]), int'(want_seq[i]));
        end
        check("t4_expired_twice", exp_cnt, 2);
        check("t4_never_done", done_cnt, 0);
        AutoReload = 0;

        // 5: clamp, zero load, load on a tick edge
        Load = 1; LoadValue = 12'hFA5;
        cyc(1);
        Load = 0;
        check("t5_clamp", int'(Count), int'(12'h995));
        Load = 1; LoadValue = 12'h000;
        cyc(1);
        Load = 0; Start = 1;
        cyc(1);
        Start = 0;
        check("t5_zero_done", int'(Done), 1);
        check("t5_zero_no_exp", int'(Expired), 0);
        Load = 1; LoadValue = 12'h050;
        cyc(1);
        Load = 0; Start = 1;
        cyc(1);
        Start = 0;
        cyc(9);
        Load = 1; LoadValue = 12'h123;
        cyc(1);
        Load = 0;
        check("t5_load_on_tick", int'(Count), int'(12'h123));
        check("t5_load_on_tick_notick", int'(Tick), 0);

        // 6: reset mid-run
        Load = 1; LoadValue = 12'h058;
        cyc(1);
        Load = 0; Start = 1;
        cyc(1);
        Start = 0;
        cyc(10);
        check("t6_count057", int'(Count), int'(12'h057));
        cyc(3);
        Reset = 0;
        cyc(1);
        check("t6_reset_count", int'(Count), int'(12'h120));
        check("t6_reset_flags", int'({Running, Done, Expired, Tick}), 0);
        Reset = 1; Start = 1;
        cyc(1);
        Start = 0;
        cyc(9);
        check("t6_div_restarted", int'(Tick), 0);
        cyc(1);
        check("t6_first_tick_count", int'(Count), int'(12'h119));

        // Random phase, checked cycle by cycle against the model
        for (int i = 0; i < 4000; i++) begin
            Reset = ($urandom_range(0, 299) != 0);
            Load  = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 1) == 0) LoadValue = 12'($urandom_range(0, 6));
            else LoadValue = 12'($urandom);
            Start = ($urandom_range(0, 7) == 0);
            Pause = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 99) == 0) AutoReload = ~AutoReload;
            cyc(1);
        end

        chk_en = 0;
        #20;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/countdown_timer_bcd.md
Name: countdown_timer_bcd

Overview:
Parametrised countdown timer with an integrated rate divider. It counts a decimal (BCD) value down at TICK_HZ and drives a per-digit BCD bus straight into the seven-segment decoders, so no binary-to-BCD stage is needed. Adds load, start, pause and one-shot/auto-reload modes, plus done and expiry indications for the game-control FSM.

Parameters:
CLK_HZ, 50000000, input clock frequency.
TICK_HZ, 1, count-down rate; DIV = CLK_HZ/TICK_HZ, must be >= 2.
DIGITS, 3, number of BCD digits (1..6).
RESET_VALUE, 12'h120, BCD value loaded at reset; width 4*DIGITS.

Ports:
Clock  in  1  system clock.
Reset  in  1  synchronous, active-low reset.
Load  in  1  load LoadValue into count, go to IDLE.
LoadValue  in  4*DIGITS  BCD preset value; digits > 9 are clamped to 9.
Start  in  1  begin or resume counting.
Pause  in  1  hold count while RUNNING.
AutoReload  in  1  0 = one-shot; 1 = reload the last loaded value on expiry and keep running.
Count  out  4*DIGITS  current BCD count; digit i is Count[4i+3:4i].
Running  out  1  high in RUNNING state.
Done  out  1  level, high in DONE state.
Expired  out  1  one-cycle pulse when the count reaches 0 through a tick.
Tick  out  1  one-cycle divider strobe, for debug and LEDs.

Behaviour:
- Reset (Reset==0 at posedge Clock): Count=RESET_VALUE; reload register=RESET_VALUE; divider=0; state IDLE; Running=0; Done=0; Expired=0; Tick=0.
- States: IDLE, RUNNING, PAUSED, DONE. Outputs are registered.
- Input priority, highest first: Reset > Load > Pause > Start.
- Load (any state): Count and reload register take the clamped LoadValue; divider=0; state IDLE; Done=0. A loaded value of 0 still goes to IDLE.
- IDLE: Start -> RUNNING, but only if Count != 0. If Count == 0, Start -> DONE with no Expired pulse.
- RUNNING: the divider increments each cycle. At DIV-1 it wraps to 0 and asserts Tick for one cycle. On a Tick, Count is decremented in BCD:
  - a digit at 0 becomes 9 and borrows from the next digit;
  - the first tick arrives DIV cycles after entering RUNNING.
- Pause in RUNNING -> PAUSED. The divider value is held, so the partial second is preserved. PAUSED + Start (and no Pause) -> RUNNING.
- Expiry: a tick that takes Count from 1 to 0 asserts Expired in the same cycle that Count shows 0.
  - One-shot: -> DONE; Done=1 from that cycle on; Running=0.
  - AutoReload: on the next tick Count = reload register and the state stays RUNNING, so the 0 value is held for one full tick period. Done is never set.
- DONE: Count holds at 0. Start is ignored. Exit only via Load or Reset.
- Pause and Start asserted together: Pause wins.
- A Load coinciding with a tick: Load wins, and the tick's decrement is discarded.
- No underflow: Count never wraps below 0 in one-shot mode.
- Tick is asserted only in RUNNING.

Decomposition:
- Package timer_pkg: state enum (IDLE, RUNNING, PAUSED, DONE), BCD_W=4, a BCD-clamp function, and a BCD-decrement function over DIGITS.
- Sub-module tick_divider (CLK_HZ, TICK_HZ; ports Clock, Reset, Enable, Clear, Tick) holds the divider counter.
- The top level holds the FSM, the BCD counter and the reload register.

Test Plan (CLK_HZ=10, TICK_HZ=1, so DIV=10; DIGITS=3):
1. Reset, then Start -> Count=120, Running=1. First Tick 10 cycles later gives Count=119. After 21 ticks Count=099, checking the borrow across two digits.
2. Load 12'h003, Start, one-shot -> Count 002, 001, 000. Expired pulses exactly once with Count=000. Done=1 stays high. A later Start changes nothing.
3. Pause asserted 4 cycles into a tick period, held 30 cycles, then Start -> no Tick while paused. The next Tick arrives 6 cycles after resume.
4. AutoReload=1, Load 12'h002, Start -> sequence 002, 001, 000 (Expired), 002, 001, 000 (Expired). Done stays 0 throughout.
5. Load 12'hFA5 -> Count=995 (digits clamped). Load 12'h000 then Start -> DONE with no Expired pulse. Load on the same cycle as a Tick -> Count=LoadValue.
6. Reset driven low mid-RUNNING at Count=057 -> next cycle Count=120, state IDLE, all flags 0, divider restarted.
